// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between requesters, the round-robin arbiter and the
// asynchronous FIFO write side. The master side drives requests and the FIFO
// full flag. The slave side (the arbiter) returns ready, the FIFO write
// strobe and data, and its grant status.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         arb_wr_data;
  logic                      arb_wr_en;
  logic                      wr_full;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_data, req_last, wr_full,
    input  req_ready, arb_wr_data, arb_wr_en, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, wr_full,
    output req_ready, arb_wr_data, arb_wr_en, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the single FIFO write port, in the write clock domain.
// A grant lasts for one packet or MAX_BURST beats, whichever ends first.
// One idle cycle always separates consecutive grants.
// Optional: define FIFO_WR_ARB_STALL_TIMEOUT_EN to force-release a grant.
// The release happens after STALL_MAX cycles in which the granted requester
// shows no valid beat while the FIFO is not full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int STALL_MAX = 16
) (
  input  logic             wr_clk,
  input  logic             wr_rstn,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  localparam logic [BC_W-1:0]  BURST_END = BC_W'(MAX_BURST - 1);
  localparam logic [GID_W-1:0] LAST_ID   = GID_W'(NUM_REQ - 1);
  localparam logic [GID_W:0]   NUM_REQ_W = (GID_W + 1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..255");
  end
  if (STALL_MAX < 1) begin : g_chk_stall_max
    $error("fifo_wr_arbiter: STALL_MAX must be at least 1");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state_q,    state_d;
  logic [GID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;

`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_END = STALL_W'(STALL_MAX - 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

  logic                  g_valid;
  logic                  g_last;
  logic [DATA_W-1:0]     g_data;
  logic                  accept;
  logic                  found;
  logic [GID_W-1:0]      pick_id;
  logic [GID_W:0]        pick_sum;
  logic [2*NUM_REQ-1:0]  valid_dbl;
  logic [NUM_REQ-1:0]    valid_rot;
  logic [NUM_REQ-1:0]    ready;

  // Mux out the currently granted requester's valid/last/data
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotate valids so bit 0 is rr_ptr, take the first set bit, then map back.
  always_comb begin
    valid_dbl = {bus.req_valid, bus.req_valid};
    valid_rot = NUM_REQ'(valid_dbl >> rr_ptr_q);
    found     = 1'b0;
    pick_sum  = '0;
    pick_id   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && valid_rot[k]) begin
        found    = 1'b1;
        pick_sum = {1'b0, rr_ptr_q} + (GID_W + 1)'(k);
        if (pick_sum >= NUM_REQ_W) begin
          pick_sum = pick_sum - NUM_REQ_W;
        end
        pick_id = pick_sum[GID_W-1:0];
      end
    end
  end

  assign accept = (state_q == GRANT) && g_valid && !bus.wr_full;

  // Next-state logic: arbitration in IDLE, beat counting and release in GRANT
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        if (found) begin
          state_d    = GRANT;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (g_last || (beat_cnt_q == BURST_END)) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + GID_W'(1);
          end
        end
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
        else if (!g_valid && !bus.wr_full) begin
          if (stall_cnt_q == STALL_END) begin
            stall_cnt_d = '0;
            state_d     = IDLE;
            rr_ptr_d    = (grant_id_q == LAST_ID) ? '0 : grant_id_q + GID_W'(1);
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any grant immediately
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Only the granted requester sees ready, gated by the FIFO full flag
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((state_q == GRANT) && (grant_id_q == GID_W'(i))) begin
        ready[i] = ~bus.wr_full;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.arb_wr_en   = accept;
  assign bus.arb_wr_data = accept ? g_data : '0;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter.
// Requester models feed per-requester beat queues. The monitor checks every
// FIFO write against hand-computed expectations: first beat of the grant,
// grant id and data.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 8;
  localparam int STALL_MAX = 16;

  logic wr_clk  = 1'b0;
  logic wr_rstn = 1'b0;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST),
    .STALL_MAX(STALL_MAX)
  ) dut (
    .wr_clk (wr_clk),
    .wr_rstn(wr_rstn),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0]  rq [NUM_REQ][$];   // {last, data} per requester
  logic [10:0] exp_q[$];          // {first_of_grant, id, data}
  logic [NUM_REQ-1:0] hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic pb(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic ex(input logic first, input int id, input logic [7:0] d);
    exp_q.push_back({first, 2'(id), d});
  endtask

  function automatic bit rq_pending();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq_pending()) && n < budget) begin
      @(negedge wr_clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats still expected after %0d cycles, expected 0",
               name, exp_q.size(), budget);
    end
    repeat (2) @(negedge wr_clk);
  endtask

  // Requester models: a beat retires on a valid&ready cycle
  initial begin : driver
    logic [NUM_REQ-1:0] fire;
    logic [8:0] beat;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge wr_clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && !hold[i]) begin
          beat = rq[i][0];
          bus.req_valid[i] = 1'b1;
          bus.req_last[i]  = beat[8];
          bus.req_data[i*DATA_W +: DATA_W] = beat[7:0];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
          bus.req_data[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  // Monitor: each write is checked against the scoreboard queue
  initial begin : monitor
    logic prev_busy;
    int gseq;
    int wseq;
    logic first;
    logic [10:0] e;
    prev_busy = 1'b0;
    gseq = 0;
    wseq = 0;
    forever begin
      @(negedge wr_clk);
      if (bus.busy && !prev_busy) gseq++;
      prev_busy = bus.busy;
      if (bus.arb_wr_en) begin
        first = (gseq != wseq);
        wseq  = gseq;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: got first=%0b id=%0d data=0x%02h, expected no write",
                   first, bus.grant_id, bus.arb_wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({first, bus.grant_id, bus.arb_wr_data} !== e) begin
            miscompares++;
            $display("FAIL write_beat: got first=%0b id=%0d data=0x%02h, expected first=%0b id=%0d data=0x%02h",
                     first, bus.grant_id, bus.arb_wr_data, e[10], e[9:8], e[7:0]);
          end
        end
      end else begin
        chk("wr_data_idle", 32'(bus.arb_wr_data), 32'h0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin : test
    bus.wr_full = 1'b0;
    repeat (3) @(negedge wr_clk);
    chk("rst_busy",     32'(bus.busy),        32'h0);
    chk("rst_ready",    32'(bus.req_ready),   32'h0);
    chk("rst_wr_en",    32'(bus.arb_wr_en),   32'h0);
    chk("rst_wr_data",  32'(bus.arb_wr_data), 32'h0);
    chk("rst_grant_id", 32'(bus.grant_id),    32'h0);
    wr_rstn = 1'b1;
    @(negedge wr_clk);

    // Single requester 0, 3-beat packet
    ex(1, 0, 8'h11); ex(0, 0, 8'h22); ex(0, 0, 8'h33);
    pb(0, 8'h11, 0); pb(0, 8'h22, 0); pb(0, 8'h33, 1);
    @(negedge wr_clk);
    chk("s1_idle_before_grant", 32'(bus.busy), 32'h0);
    @(negedge wr_clk);
    chk("s1_busy",     32'(bus.busy),      32'h1);
    chk("s1_grant_id", 32'(bus.grant_id),  32'h0);
    chk("s1_ready",    32'(bus.req_ready), 32'h1);
    drain("s1", 20);
    chk("s1_busy_fall", 32'(bus.busy), 32'h0);

    // All four valid with rr_ptr=1: order 1,2,3,0
    for (int s = 0; s < NUM_REQ; s++) begin
      int id;
      id = (1 + s) % NUM_REQ;
      ex(1, id, 8'(8'hA0 + 16 * id));
      ex(0, id, 8'(8'hA1 + 16 * id));
    end
    for (int id = 0; id < NUM_REQ; id++) begin
      pb(id, 8'(8'hA0 + 16 * id), 0);
      pb(id, 8'(8'hA1 + 16 * id), 1);
    end
    drain("s2", 40);

    // Burst limit: 20-beat packet from 2 interleaved with 3's packet
    for (int k = 0; k < 8; k++) ex(k == 0, 2, 8'(8'h80 + k));
    ex(1, 3, 8'hC0); ex(0, 3, 8'hC1);
    for (int k = 8; k < 16; k++) ex(k == 8, 2, 8'(8'h80 + k));
    for (int k = 16; k < 20; k++) ex(k == 16, 2, 8'(8'h80 + k));
    for (int k = 0; k < 20; k++) pb(2, 8'(8'h80 + k), k == 19);
    pb(3, 8'hC0, 0); pb(3, 8'hC1, 1);
    drain("s3", 80);

    // wr_full held for 5 cycles mid-burst; 10-beat packet splits at 8
    for (int k = 0; k < 8; k++) ex(k == 0, 1, 8'(8'h40 + k));
    ex(1, 1, 8'h48); ex(0, 1, 8'h49);
    for (int k = 0; k < 10; k++) pb(1, 8'(8'h40 + k), k == 9);
    repeat (3) @(negedge wr_clk);
    chk("s4_ready_pre_full", 32'(bus.req_ready), 32'h2);
    @(posedge wr_clk);
    #1 bus.wr_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge wr_clk);
      chk("s4_full_ready", 32'(bus.req_ready), 32'h0);
      chk("s4_full_wr_en", 32'(bus.arb_wr_en), 32'h0);
      chk("s4_full_busy",  32'(bus.busy),      32'h1);
    end
    @(posedge wr_clk);
    #1 bus.wr_full = 1'b0;
    @(negedge wr_clk);
    chk("s4_resume_wr_en", 32'(bus.arb_wr_en), 32'h1);
    drain("s4", 40);

    // Reset during beat 4 of a grant to requester 1
    ex(1, 1, 8'h50); ex(0, 1, 8'h51); ex(0, 1, 8'h52);
    for (int k = 0; k < 6; k++) pb(1, 8'(8'h50 + k), k == 5);
    repeat (4) @(negedge wr_clk);
    @(posedge wr_clk);
    #2 wr_rstn = 1'b0;
    #1;
    chk("s5_rst_busy",     32'(bus.busy),        32'h0);
    chk("s5_rst_ready",    32'(bus.req_ready),   32'h0);
    chk("s5_rst_wr_en",    32'(bus.arb_wr_en),   32'h0);
    chk("s5_rst_wr_data",  32'(bus.arb_wr_data), 32'h0);
    chk("s5_rst_grant_id", 32'(bus.grant_id),    32'h0);
    chk("s5_beats_written", 32'(exp_q.size()),   32'h0);
    rq[1].delete();
    repeat (2) @(negedge wr_clk);
    wr_rstn = 1'b1;
    @(negedge wr_clk);
    ex(1, 0, 8'hE0); ex(0, 0, 8'hE1); ex(1, 2, 8'hD0); ex(0, 2, 8'hD1);
    pb(2, 8'hD0, 0); pb(2, 8'hD1, 1);
    pb(0, 8'hE0, 0); pb(0, 8'hE1, 1);
    drain("s5", 30);

    // Granted requester 1 stalls after 2 beats while requester 3 waits
`ifdef FIFO_WR_ARB_STALL_TIMEOUT_EN
    ex(1, 1, 8'h60); ex(0, 1, 8'h61);
    ex(1, 3, 8'h70); ex(0, 3, 8'h71);
    ex(1, 1, 8'h62); ex(0, 1, 8'h63);
`else
    ex(1, 1, 8'h60); ex(0, 1, 8'h61); ex(0, 1, 8'h62); ex(0, 1, 8'h63);
    ex(1, 3, 8'h70); ex(0, 3, 8'h71);
`endif
    for (int k = 0; k < 4; k++) pb(1, 8'(8'h60 + k), k == 3);
    repeat (3) @(negedge wr_clk);
    hold[1] = 1'b1;
    pb(3, 8'h70, 0); pb(3, 8'h71, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge wr_clk);
`ifndef FIFO_WR_ARB_STALL_TIMEOUT_EN
      chk("s6_hold_busy",     32'(bus.busy),      32'h1);
      chk("s6_hold_grant_id", 32'(bus.grant_id),  32'h1);
      chk("s6_hold_wr_en",    32'(bus.arb_wr_en), 32'h0);
`endif
    end
    hold[1] = 1'b0;
    drain("s6", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
